// File: rtl/action_pkt_sched_pkg.sv
// Shared openflow scheduler definitions: FSM state encoding, action drop-bit index,
// action queue depth and the default action word width.
`ifndef OF_ACTION_DATA_WIDTH
`define OF_ACTION_DATA_WIDTH 32
`endif

package action_pkt_sched_pkg;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_XFER = 2'd1,
    ST_DROP = 2'd2
  } sched_state_e;

  localparam int unsigned OF_ACT_DROP_BIT     = 0;
  localparam int unsigned ACT_FIFO_DEPTH_BITS = 2;

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small fall-through FIFO: head word visible on dout while not empty; writes when
// full and reads when empty are ignored. Exposes occupancy for threshold logic.
module fallthrough_small_fifo #(
  parameter int WIDTH          = 72,
  parameter int MAX_DEPTH_BITS = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WIDTH-1:0]        din,
  input  logic                    wr_en,
  input  logic                    rd_en,
  output logic [WIDTH-1:0]        dout,
  output logic                    empty,
  output logic [MAX_DEPTH_BITS:0] count
);

  localparam int unsigned DEPTH = 1 << MAX_DEPTH_BITS;
  localparam logic [MAX_DEPTH_BITS:0] FULL_CNT = {1'b1, {MAX_DEPTH_BITS{1'b0}}};

  logic [WIDTH-1:0]          mem_q [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [MAX_DEPTH_BITS:0]   cnt_q, cnt_d;
  logic                      do_wr, do_rd;

  always_comb begin
    empty    = (cnt_q == '0);
    count    = cnt_q;
    dout     = mem_q[rd_ptr_q];
    do_wr    = wr_en && (cnt_q != FULL_CNT);
    do_rd    = rd_en && !empty;
    wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({do_wr, do_rd})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/action_pkt_sched.sv
// Binds queued matcher actions to buffered packets and forwards or drops each packet.
// Define ACTION_PKT_SCHED_STATS_EN to build the forwarded/dropped packet counters.
`ifndef OF_ACTION_DATA_WIDTH
`define OF_ACTION_DATA_WIDTH 32
`endif

module action_pkt_sched import action_pkt_sched_pkg::*; #(
  parameter int DATA_WIDTH          = 64,
  parameter int CTRL_WIDTH          = DATA_WIDTH / 8,
  parameter int ACT_WIDTH           = `OF_ACTION_DATA_WIDTH,
  parameter int ACT_DROP_BIT        = OF_ACT_DROP_BIT,
  parameter int PKT_FIFO_DEPTH_BITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  input  logic [ACT_WIDTH-1:0]  action_data,
  input  logic                  action_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  output logic [ACT_WIDTH-1:0]  cur_action,
  output logic                  act_ovf_err,
  output logic [31:0]           fwd_cnt,
  output logic [31:0]           drop_cnt
);

  localparam int PKT_W = CTRL_WIDTH + DATA_WIDTH;
  localparam logic [PKT_FIFO_DEPTH_BITS:0] PKT_NEARLY = {1'b0, {PKT_FIFO_DEPTH_BITS{1'b1}}};
  localparam logic [ACT_FIFO_DEPTH_BITS:0] ACT_FULL   = {1'b1, {ACT_FIFO_DEPTH_BITS{1'b0}}};

  logic [PKT_W-1:0]               pkt_dout;
  logic                           pkt_empty, pkt_rd;
  logic [PKT_FIFO_DEPTH_BITS:0]   pkt_cnt;
  logic [ACT_WIDTH-1:0]           act_head;
  logic                           act_empty, act_full, act_wr, act_rd;
  logic [ACT_FIFO_DEPTH_BITS:0]   act_cnt;

  sched_state_e         state_q, state_d;
  logic [ACT_WIDTH-1:0] cur_action_q, cur_action_d;
  logic                 body_seen_q, body_seen_d;
  logic                 act_ovf_err_q, act_ovf_err_d;
  logic                 eop;

  fallthrough_small_fifo #(
    .WIDTH          (PKT_W),
    .MAX_DEPTH_BITS (PKT_FIFO_DEPTH_BITS)
  ) u_pkt_fifo (
    .clk   (clk),
    .reset (reset),
    .din   ({in_ctrl, in_data}),
    .wr_en (in_wr),
    .rd_en (pkt_rd),
    .dout  (pkt_dout),
    .empty (pkt_empty),
    .count (pkt_cnt)
  );

  fallthrough_small_fifo #(
    .WIDTH          (ACT_WIDTH),
    .MAX_DEPTH_BITS (ACT_FIFO_DEPTH_BITS)
  ) u_act_fifo (
    .clk   (clk),
    .reset (reset),
    .din   (action_data),
    .wr_en (act_wr),
    .rd_en (act_rd),
    .dout  (act_head),
    .empty (act_empty),
    .count (act_cnt)
  );

  always_comb begin
    out_data      = pkt_dout[DATA_WIDTH-1:0];
    out_ctrl      = pkt_dout[PKT_W-1:DATA_WIDTH];
    in_rdy        = !(pkt_cnt >= PKT_NEARLY);
    act_full      = (act_cnt == ACT_FULL);
    act_wr        = action_valid && !act_full;
    act_ovf_err_d = act_ovf_err_q || (action_valid && act_full);
    state_d       = state_q;
    cur_action_d  = cur_action_q;
    body_seen_d   = body_seen_q;
    out_wr        = 1'b0;
    pkt_rd        = 1'b0;
    act_rd        = 1'b0;
    case (state_q)
      ST_WAIT: if (!act_empty) begin
        cur_action_d = act_head;
        state_d      = act_head[ACT_DROP_BIT] ? ST_DROP : ST_XFER;
      end
      ST_XFER: begin
        out_wr = !pkt_empty && out_rdy;
        pkt_rd = out_wr;
      end
      ST_DROP: pkt_rd = !pkt_empty;
      default: state_d = ST_WAIT;
    endcase
    // A non-zero ctrl word only closes a packet once a ctrl==0 body word has gone by.
    eop = pkt_rd && (out_ctrl != '0) && body_seen_q;
    if (pkt_rd) body_seen_d = eop ? 1'b0 : (body_seen_q || (out_ctrl == '0));
    if (eop) begin
      act_rd  = 1'b1;
      state_d = ST_WAIT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_WAIT;
      cur_action_q  <= '0;
      body_seen_q   <= 1'b0;
      act_ovf_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_action_q  <= cur_action_d;
      body_seen_q   <= body_seen_d;
      act_ovf_err_q <= act_ovf_err_d;
    end
  end

  always_comb begin
    cur_action  = cur_action_q;
    act_ovf_err = act_ovf_err_q;
  end

`ifdef ACTION_PKT_SCHED_STATS_EN
  logic [31:0] fwd_cnt_q, fwd_cnt_d, drop_cnt_q, drop_cnt_d;

  always_comb begin
    fwd_cnt_d  = fwd_cnt_q  + ((eop && state_q == ST_XFER) ? 32'd1 : 32'd0);
    drop_cnt_d = drop_cnt_q + ((eop && state_q == ST_DROP) ? 32'd1 : 32'd0);
    fwd_cnt    = fwd_cnt_q;
    drop_cnt   = drop_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      fwd_cnt_q  <= fwd_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end
`else
  always_comb begin
    fwd_cnt  = '0;
    drop_cnt = '0;
  end
`endif

endmodule

// File: tb/tb_action_pkt_sched.sv
// Bench for action_pkt_sched: directed scenarios plus randomized packets/actions,
// checked against a packet-level pairing model (nth packet takes nth accepted action).
`timescale 1ns/1ps

module tb_action_pkt_sched;

  localparam int DW = 64;
  localparam int CW = 8;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          in_wr;
  logic          in_rdy;
  logic [AW-1:0] action_data;
  logic          action_valid;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic          out_wr;
  logic          out_rdy;
  logic [AW-1:0] cur_action;
  logic          act_ovf_err;
  logic [31:0]   fwd_cnt;
  logic [31:0]   drop_cnt;

  action_pkt_sched #(
    .DATA_WIDTH          (DW),
    .CTRL_WIDTH          (CW),
    .ACT_WIDTH           (AW),
    .ACT_DROP_BIT        (0),
    .PKT_FIFO_DEPTH_BITS (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_ctrl      (in_ctrl),
    .in_wr        (in_wr),
    .in_rdy       (in_rdy),
    .action_data  (action_data),
    .action_valid (action_valid),
    .out_data     (out_data),
    .out_ctrl     (out_ctrl),
    .out_wr       (out_wr),
    .out_rdy      (out_rdy),
    .cur_action   (cur_action),
    .act_ovf_err  (act_ovf_err),
    .fwd_cnt      (fwd_cnt),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
    logic          last;
  } word_t;

  typedef struct packed {
    logic [AW-1:0] act;
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } out_t;

  word_t         pkt_m [$];
  logic [AW-1:0] act_m [$];
  out_t          exp_q [$];
  int            pkt_pending;
  int            fwd_exp, drop_exp;
  logic          ovf_exp;
  int            n_checks, n_errors;
  int            rdy_mode;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pair waiting packets with waiting actions in arrival order.
  function automatic void resolve();
    logic [AW-1:0] a;
    word_t         w;
    while (pkt_pending > 0 && act_m.size() > 0) begin
      a = act_m.pop_front();
      pkt_pending--;
      do begin
        w = pkt_m.pop_front();
        if (!a[0]) exp_q.push_back({a, w.ctrl, w.data});
      end while (!w.last);
      if (a[0]) drop_exp++;
      else      fwd_exp++;
    end
  endfunction

  function automatic void clear_model();
    pkt_m.delete();
    act_m.delete();
    exp_q.delete();
    pkt_pending = 0;
    fwd_exp     = 0;
    drop_exp    = 0;
    ovf_exp     = 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outs();
    check("rst_out_wr", out_wr, 1'b0);
    check("rst_cur_action", cur_action, '0);
    check("rst_ovf", act_ovf_err, 1'b0);
    check("rst_fwd_cnt", fwd_cnt, '0);
    check("rst_drop_cnt", drop_cnt, '0);
    check("rst_in_rdy", in_rdy, 1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_model();
    check_reset_outs();
  endtask

  task automatic send_action(input logic [AW-1:0] a);
    action_valid = 1'b1;
    action_data  = a;
    if (act_m.size() >= 4) ovf_exp = 1'b1;
    else begin
      act_m.push_back(a);
      resolve();
    end
    tick();
    action_valid = 1'b0;
  endtask

  task automatic send_pkt(input int len, input logic [CW-1:0] last_ctrl, input bit act_last,
                          input logic [AW-1:0] a, input int reset_at);
    word_t w [$];
    word_t cur;
    int    waited;
    for (int i = 0; i < len; i++) begin
      cur.ctrl = (i == 0) ? 8'hFF : ((i == len - 1) ? last_ctrl : 8'h00);
      cur.data = {$urandom(), $urandom()};
      cur.last = (i == len - 1);
      w.push_back(cur);
      pkt_m.push_back(cur);
    end
    pkt_pending++;
    resolve();
    for (int i = 0; i < len; i++) begin
      waited = 0;
      while (!in_rdy && waited < 500) begin
        tick();
        waited++;
      end
      if (!in_rdy) begin
        check("in_rdy_stall", in_rdy, 1'b1);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "input side stalled");
      end
      in_wr   = 1'b1;
      in_ctrl = w[i].ctrl;
      in_data = w[i].data;
      if (act_last && w[i].last) begin
        action_valid = 1'b1;
        action_data  = a;
        act_m.push_back(a);
        resolve();
      end
      if (i == reset_at) reset = 1'b1;
      tick();
      in_wr        = 1'b0;
      action_valid = 1'b0;
      if (i == reset_at) begin
        reset = 1'b0;
        clear_model();
        check_reset_outs();
        return;
      end
    end
  endtask

  task automatic settle(input string tag);
    int n;
    int fe, de;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      tick();
      n++;
    end
    repeat (12) tick();
`ifdef ACTION_PKT_SCHED_STATS_EN
    fe = fwd_exp;
    de = drop_exp;
`else
    fe = 0;
    de = 0;
`endif
    check($sformatf("%s_drained", tag), exp_q.size(), 0);
    check($sformatf("%s_fwd_cnt", tag), fwd_cnt, fe);
    check($sformatf("%s_drop_cnt", tag), drop_cnt, de);
    check($sformatf("%s_ovf", tag), act_ovf_err, ovf_exp);
    check($sformatf("%s_in_rdy", tag), in_rdy, 1'b1);
  endtask

  task automatic wait_backlog(input int lim);
    int n;
    n = 0;
    while (exp_q.size() > lim && n < 1000) begin
      tick();
      n++;
    end
    if (exp_q.size() > lim) check("backlog_timeout", exp_q.size(), lim);
  endtask

  initial begin
    out_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       out_rdy = 1'($urandom_range(0, 1));
        2:       out_rdy = ~out_rdy;
        default: out_rdy = 1'b1;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!reset && out_wr) begin
      check("wr_with_rdy", out_rdy, 1'b1);
      if (exp_q.size() == 0) check("unexpected_wr", out_wr, 1'b0);
      else check("out_word", {cur_action, out_ctrl, out_data}, exp_q.pop_front());
    end
  end

  initial begin
    logic [AW-1:0] a;
    int            len, mode;
    n_checks     = 0;
    n_errors     = 0;
    rdy_mode     = 0;
    reset        = 1'b1;
    in_data      = '0;
    in_ctrl      = '0;
    in_wr        = 1'b0;
    action_data  = '0;
    action_valid = 1'b0;
    clear_model();
    repeat (2) tick();
    reset = 1'b0;
    check_reset_outs();

    send_action(32'h0);
    send_pkt(4, 8'h01, 1'b0, '0, -1);
    settle("fwd_basic");

    send_pkt(7, 8'h01, 1'b0, '0, -1);
    repeat (10) tick();
    check("full_in_rdy", in_rdy, 1'b0);
    check("no_early_wr", out_wr, 1'b0);
    send_action(32'h0000_0001);
    settle("drop_late");

    rdy_mode = 2;
    send_action(32'h0000_0A02);
    send_pkt(5, 8'h0F, 1'b0, '0, -1);
    settle("rdy_toggle");
    rdy_mode = 0;

    do_reset();
    for (int i = 1; i <= 4; i++) send_action(AW'(i * 16));
    check("ovf_after_4", act_ovf_err, 1'b0);
    send_action(32'h0000_0050);
    check("ovf_after_5", act_ovf_err, 1'b1);
    for (int i = 0; i < 4; i++) send_pkt(3 + i, 8'h01, 1'b0, '0, -1);
    settle("ovf_order");

    do_reset();
    send_action(32'h0000_0020);
    send_pkt(6, 8'h01, 1'b0, '0, 2);
    send_action(32'h0000_0030);
    send_pkt(6, 8'h01, 1'b0, '0, -1);
    settle("post_reset");

    rdy_mode = 1;
    for (int p = 0; p < 40; p++) begin
      wait_backlog(3);
      len  = $urandom_range(3, 7);
      a    = $urandom();
      a[0] = ($urandom_range(0, 3) == 0);
      mode = $urandom_range(0, 2);
      if (mode == 0) begin
        send_action(a);
        send_pkt(len, 8'($urandom_range(1, 255)), 1'b0, '0, -1);
      end else if (mode == 1) begin
        send_pkt(len, 8'($urandom_range(1, 255)), 1'b1, a, -1);
      end else begin
        send_pkt(len, 8'($urandom_range(1, 255)), 1'b0, '0, -1);
        repeat ($urandom_range(0, 5)) tick();
        send_action(a);
      end
    end
    rdy_mode = 0;
    settle("random");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/action_pkt_sched.md
ACTION_PKT_SCHED -- requirements
Module: action_pkt_sched

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, packet word width.
REQ-002 SHALL have parameter CTRL_WIDTH, default DATA_WIDTH/8, control byte-lane width.
REQ-003 SHALL have parameter ACT_WIDTH, default `OF_ACTION_DATA_WIDTH, action word width.
REQ-004 SHALL have parameter ACT_DROP_BIT, default 0, index in action_data of the drop flag.
REQ-005 SHALL have parameter PKT_FIFO_DEPTH_BITS, default 3, log2 of packet buffer depth.
REQ-006 SHALL have ports, in order:
- clk, in, 1: sole clock.
- reset, in, 1: synchronous, active-high.
- in_data, in, DATA_WIDTH: packet word.
- in_ctrl, in, CTRL_WIDTH: packet control.
- in_wr, in, 1: packet word valid.
- in_rdy, out, 1: packet buffer can accept.
- action_data, in, ACT_WIDTH: action from matcher.
- action_valid, in, 1: one-cycle action strobe.
- out_data, out, DATA_WIDTH: packet word to action processor.
- out_ctrl, out, CTRL_WIDTH: packet control to action processor.
- out_wr, out, 1: output word valid.
- out_rdy, in, 1: downstream ready.
- cur_action, out, ACT_WIDTH: action bound to the packet in flight.
- act_ovf_err, out, 1: sticky action-queue overflow.
- fwd_cnt, out, 32: forwarded packets.
- drop_cnt, out, 32: dropped packets.

Function
REQ-007 SHALL buffer packet words in a fall-through FIFO; in_rdy = !nearly_full (at most 1 free entry).
REQ-008 SHALL queue actions in a 4-entry fall-through FIFO, one entry per action_valid cycle.
REQ-009 SHALL, on action_valid while the action FIFO is full, discard that action and set act_ovf_err.
REQ-010 SHALL implement states WAIT, XFER, DROP; reset state WAIT.
REQ-011 SHALL, in WAIT, move to XFER if action FIFO non-empty and head drop bit = 0, to DROP if drop bit = 1, else stay.
REQ-012 SHALL drive cur_action from the action FIFO head, registered on leaving WAIT, held until the packet's EOP is consumed.
REQ-013 SHALL, in XFER, assert out_wr and pop one packet word in the same cycle iff packet FIFO non-empty and out_rdy = 1.
REQ-014 SHALL, in DROP, pop one packet word per cycle while packet FIFO non-empty, out_rdy ignored, out_wr = 0.
REQ-015 SHALL define EOP as a popped word with ctrl != 0 following at least one popped word of the same packet with ctrl = 0.
REQ-016 SHALL, on EOP pop, pop the action FIFO, increment fwd_cnt (XFER) or drop_cnt (DROP), and return to WAIT the next cycle.
REQ-017 SHALL make out_data/out_ctrl combinational from packet FIFO head; out_wr combinational from state, empty and out_rdy (zero added latency).
REQ-018 SHALL let counters wrap from 0xFFFFFFFF to 0.
REQ-019 SHALL treat an action arriving in the EOP cycle as queued normally (no loss, no reorder).

Reset
REQ-020 SHALL on reset: state WAIT, both FIFOs empty, cur_action 0, act_ovf_err 0, fwd_cnt 0, drop_cnt 0, out_wr 0.
REQ-021 SHALL discard any partial packet and pending actions on reset mid-packet; first post-reset word is a new packet.

Configuration
REQ-022 SHALL, with ACTION_PKT_SCHED_STATS_EN defined, implement fwd_cnt/drop_cnt per REQ-016/018; without it, tie both to 0 and instantiate no counter flops.

Structure
REQ-023 SHALL place state encodings and the action drop-bit constant in the shared openflow package/defines file.
REQ-024 SHALL reuse fallthrough_small_fifo for both queues; no other sub-module.

Verification
REQ-025 Action 0x0 then 4-word packet (ctrl FF,0,0,01), out_rdy=1 -> 4 out_wr cycles, fwd_cnt=1, cur_action=0x0 throughout.
REQ-026 Packet first, action (drop bit=1) 10 cycles later -> no out_wr, packet drained, drop_cnt=1, in_rdy recovers.
REQ-027 Forward packet with out_rdy toggling 1,0,1,0 -> words emitted only on out_rdy=1, order and ctrl preserved.
REQ-028 Five action_valid strobes with no packets -> act_ovf_err=1 after fifth; four packets then consume four actions in order.
REQ-029 reset asserted on word 2 of a 6-word forward packet -> all outputs per REQ-020 next cycle; next full packet forwarded correctly.
REQ-030 Build without ACTION_PKT_SCHED_STATS_EN, run REQ-025 -> forwarding identical, fwd_cnt=drop_cnt=0.
